// File: rtl/atahost_pio_tctrl_md.sv
// atahost_pio_tctrl_md: ATA PIO cycle timing controller with two device timing sets.
// Optional IORDY timeout: define ATAHOST_PIO_IORDY_TIMEOUT_EN.
module atahost_pio_tctrl_md #(
   parameter int TWIDTH         = 8,
   parameter int TOWIDTH        = 16,
   parameter int PIO_MODE0_T1   = 6,
   parameter int PIO_MODE0_T2   = 28,
   parameter int PIO_MODE0_T4   = 2,
   parameter int PIO_MODE0_TEOC = 23
) (
   input  logic                  clk,
   input  logic                  nReset,
   input  logic                  rst,
   input  logic [4*TWIDTH-1:0]   T_d0,
   input  logic [4*TWIDTH-1:0]   T_d1,
   input  logic                  ld_d0,
   input  logic                  ld_d1,
   input  logic [1:0]            IORDY_en,
   input  logic [TOWIDTH-1:0]    Tto,
   input  logic                  go,
   input  logic                  dev,
   input  logic                  we,
   input  logic                  IORDY,
   input  logic                  clr_to,
   output logic                  busy,
   output logic                  oe,
   output logic                  done,
   output logic                  dstrb,
   output logic                  DIOR,
   output logic                  DIOW,
   output logic                  timeout
);

   localparam int TW4 = 4 * TWIDTH;
   localparam logic [TW4-1:0] TDEF = {TWIDTH'(PIO_MODE0_TEOC), TWIDTH'(PIO_MODE0_T4),
                                      TWIDTH'(PIO_MODE0_T2), TWIDTH'(PIO_MODE0_T1)};
   localparam logic [TWIDTH-1:0]  T_ONE  = TWIDTH'(1);
   localparam logic [TOWIDTH-1:0] TO_ONE = TOWIDTH'(1);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_RDY, HOLD} state_t;

   // A programmed zero behaves as a one-clock phase
   function automatic logic [TWIDTH-1:0] eff(input logic [TWIDTH-1:0] v);
      return (v == '0) ? T_ONE : v;
   endfunction

   state_t                state_q, state_d;
   logic [TWIDTH-1:0]     cnt_q, cnt_d;
   logic [TWIDTH-1:0]     t4c_q, t4c_d;
   logic [TW4-1:0]        td0_q, td0_d;
   logic [TW4-1:0]        td1_q, td1_d;
   logic [3*TWIDTH-1:0]   tc_q, tc_d;
   logic                  en_q, en_d;
   logic                  we_q, we_d;
   logic                  qv_q, qv_d;
   logic                  qdev_q, qdev_d;
   logic                  qwe_q, qwe_d;
   logic                  oe_q, oe_d;
   logic                  done_q, done_d;
   logic                  dstrb_q, dstrb_d;

   logic                  acc, adev, awe, hold_go, rdy, tmo_hit;
   logic [TW4-1:0]        aset;
   logic [TWIDTH-1:0]     m4, me, hl;

   assign rdy = IORDY | ~en_q;

   // Request queue, cycle sequencing and strobe/handshake timing
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      t4c_d   = t4c_q;
      td0_d   = td0_q;
      td1_d   = td1_q;
      tc_d    = tc_q;
      en_d    = en_q;
      we_d    = we_q;
      qv_d    = qv_q;
      qdev_d  = qdev_q;
      qwe_d   = qwe_q;
      oe_d    = oe_q;
      done_d  = 1'b0;
      dstrb_d = 1'b0;
      acc     = 1'b0;
      adev    = dev;
      awe     = we;
      hold_go = 1'b0;

      if (ld_d0) td0_d = T_d0;
      if (ld_d1) td1_d = T_d1;

      if (state_q != IDLE) begin
         if (go && !qv_q) begin
            qv_d   = 1'b1;
            qdev_d = dev;
            qwe_d  = we;
         end
      end else if (qv_q) begin
         acc  = 1'b1;
         adev = qdev_q;
         awe  = qwe_q;
         qv_d = go;
         if (go) begin
            qdev_d = dev;
            qwe_d  = we;
         end
      end else begin
         acc = go;
      end

      aset = adev ? td1_q : td0_q;
      m4   = eff(tc_q[2*TWIDTH-1:TWIDTH]);
      me   = eff(tc_q[3*TWIDTH-1:2*TWIDTH]);
      hl   = (m4 > me) ? m4 : me;

      if (state_q == HOLD && t4c_q != '0) begin
         t4c_d = t4c_q - T_ONE;
         if (t4c_q == T_ONE) begin
            done_d = 1'b1;
            oe_d   = 1'b0;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (acc) begin
               state_d = SETUP;
               tc_d    = aset[TW4-1:TWIDTH];
               en_d    = IORDY_en[adev];
               we_d    = awe;
               oe_d    = awe;
               cnt_d   = eff(aset[TWIDTH-1:0]);
            end
         end
         SETUP: begin
            if (cnt_q == T_ONE) begin
               state_d = STROBE;
               cnt_d   = eff(tc_q[TWIDTH-1:0]);
            end else begin
               cnt_d = cnt_q - T_ONE;
            end
         end
         STROBE: begin
            if (cnt_q == T_ONE) begin
               if (rdy) hold_go = 1'b1;
               else     state_d = WAIT_RDY;
            end else begin
               cnt_d = cnt_q - T_ONE;
            end
         end
         WAIT_RDY: begin
            if (rdy || tmo_hit) hold_go = 1'b1;
         end
         HOLD: begin
            if (cnt_q == T_ONE) state_d = IDLE;
            else                cnt_d   = cnt_q - T_ONE;
         end
         default: state_d = IDLE;
      endcase

      if (hold_go) begin
         state_d = HOLD;
         cnt_d   = hl;
         t4c_d   = m4;
         dstrb_d = ~we_q & ~tmo_hit;
      end

      if (rst) begin
         state_d = IDLE;
         cnt_d   = '0;
         t4c_d   = '0;
         td0_d   = TDEF;
         td1_d   = TDEF;
         tc_d    = '0;
         en_d    = 1'b0;
         we_d    = 1'b0;
         qv_d    = 1'b0;
         qdev_d  = 1'b0;
         qwe_d   = 1'b0;
         oe_d    = 1'b0;
         done_d  = 1'b0;
         dstrb_d = 1'b0;
      end
   end

   // Main state and timing registers
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         t4c_q   <= '0;
         td0_q   <= TDEF;
         td1_q   <= TDEF;
         tc_q    <= '0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         qv_q    <= 1'b0;
         qdev_q  <= 1'b0;
         qwe_q   <= 1'b0;
         oe_q    <= 1'b0;
         done_q  <= 1'b0;
         dstrb_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t4c_q   <= t4c_d;
         td0_q   <= td0_d;
         td1_q   <= td1_d;
         tc_q    <= tc_d;
         en_q    <= en_d;
         we_q    <= we_d;
         qv_q    <= qv_d;
         qdev_q  <= qdev_d;
         qwe_q   <= qwe_d;
         oe_q    <= oe_d;
         done_q  <= done_d;
         dstrb_q <= dstrb_d;
      end
   end

`ifdef ATAHOST_PIO_IORDY_TIMEOUT_EN
   logic [TOWIDTH-1:0] toc_q, toc_d;
   logic               to_q, to_d;

   assign tmo_hit = (state_q == WAIT_RDY) && !rdy &&
                    (Tto != '0) && (toc_q == TO_ONE);

   // WAIT_RDY down-counter and sticky timeout flag; a new timeout beats clr_to
   always_comb begin
      toc_d = toc_q;
      to_d  = to_q;
      if (state_q != WAIT_RDY)  toc_d = Tto;
      else if (toc_q != '0)     toc_d = toc_q - TO_ONE;
      if (clr_to)  to_d = 1'b0;
      if (tmo_hit) to_d = 1'b1;
      if (rst) begin
         toc_d = '0;
         to_d  = 1'b0;
      end
   end

   // Timeout registers
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         toc_q <= '0;
         to_q  <= 1'b0;
      end else begin
         toc_q <= toc_d;
         to_q  <= to_d;
      end
   end

   assign timeout = to_q;
`else
   logic unused_to;
   assign unused_to = ^{Tto, clr_to};
   assign tmo_hit   = 1'b0;
   assign timeout   = 1'b0;
`endif

   assign busy  = (state_q != IDLE);
   assign DIOR  = (state_q == STROBE || state_q == WAIT_RDY) && !we_q;
   assign DIOW  = (state_q == STROBE || state_q == WAIT_RDY) &&  we_q;
   assign oe    = oe_q;
   assign done  = done_q;
   assign dstrb = dstrb_q;

endmodule

// File: tb/tb_atahost_pio_tctrl_md.sv
// tb_atahost_pio_tctrl_md: scoreboard bench for the PIO timing controller.
// Expected cycle shapes come from a phase-length model of each request.
module tb_atahost_pio_tctrl_md;

   localparam int TW  = 8;
   localparam int TOW = 16;

   logic clk = 1'b0;
   logic nReset, rst, ld_d0, ld_d1, go, dev, we, IORDY, clr_to;
   logic [4*TW-1:0] T_d0, T_d1;
   logic [1:0] IORDY_en;
   logic [TOW-1:0] Tto;
   logic busy, oe, done, dstrb, DIOR, DIOW, timeout;

   atahost_pio_tctrl_md #(.TWIDTH(TW), .TOWIDTH(TOW)) dut (
      .clk(clk), .nReset(nReset), .rst(rst),
      .T_d0(T_d0), .T_d1(T_d1), .ld_d0(ld_d0), .ld_d1(ld_d1),
      .IORDY_en(IORDY_en), .Tto(Tto), .go(go), .dev(dev), .we(we),
      .IORDY(IORDY), .clr_to(clr_to), .busy(busy), .oe(oe), .done(done),
      .dstrb(dstrb), .DIOR(DIOR), .DIOW(DIOW), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int t1; int slen; int t4; int hl;
      bit we; bit ds; bit to; bit queued; int iss;
   } exp_t;

   exp_t sb[$];
   int   lq[$];
   int   m_t[2][4];
   bit   m_sticky;
   int   checks = 0;
   int   failures = 0;

   function automatic int ef(int v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic exp_t mk(bit d, bit w, int L, bit q);
      exp_t e;
      int t2, te, need;
      e.t1 = ef(m_t[d][0]);
      t2   = ef(m_t[d][1]);
      e.t4 = ef(m_t[d][2]);
      te   = ef(m_t[d][3]);
      e.hl = (e.t4 > te) ? e.t4 : te;
      e.we = w; e.queued = q; e.iss = cyc; e.to = 1'b0;
      need = (IORDY_en[d] && L + 1 > t2) ? L + 1 : t2;
`ifdef ATAHOST_PIO_IORDY_TIMEOUT_EN
      if (IORDY_en[d] && Tto != 0 && need - t2 > int'(Tto)) begin
         need = t2 + int'(Tto);
         e.to = 1'b1;
      end
`endif
      e.slen = need;
      e.ds = !w && !e.to;
      return e;
   endfunction

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_t[0] = '{6, 28, 2, 23};
      m_t[1] = '{6, 28, 2, 23};
      m_sticky = 1'b0;
   endtask

   // device model: IORDY low for the first L strobe clocks of each cycle
   bit in_s = 1'b0;
   int sj = 0, cl = 0;
   always @(negedge clk) begin
      if (DIOR || DIOW) begin
         if (!in_s) begin
            in_s = 1'b1;
            sj = 0;
            cl = (lq.size() != 0) ? lq.pop_front() : 0;
         end
         IORDY = (sj >= cl);
         sj++;
      end else begin
         in_s = 1'b0;
         IORDY = 1'b1;
      end
   end

   // monitor: measures each cycle and scores it when busy drops
   bit trk = 1'b0, pb = 1'b0;
   int st, nr, nw, sf, sl, nd, dc, ndn, dnc, noe, of, last_end;

   task automatic fin();
      exp_t e;
      if (sb.size() == 0) begin
         checks++; failures++;
         $display("FAIL unexpected_cycle actual=started@%0d expected=none", st);
         return;
      end
      e = sb.pop_front();
      if (e.queued) chk("start_queued", st, last_end + 1);
      else          chk("start", st, e.iss + 1);
      chk("setup_len", sf - st, e.t1);
      chk(e.we ? "diow_len" : "dior_len", e.we ? nw : nr, e.slen);
      chk("wrong_strobe", e.we ? nr : nw, 0);
      chk("strobe_span", sl - sf + 1, e.slen);
      chk("dstrb_cnt", nd, e.ds ? 1 : 0);
      if (e.ds) chk("dstrb_pos", dc, sl + 1);
      chk("done_cnt", ndn, 1);
      chk("done_pos", dnc - sl - 1, e.t4);
      chk("hold_len", cyc - sl - 1, e.hl);
      chk("oe_cnt", noe, e.we ? e.t1 + e.slen + e.t4 : 0);
      if (e.we) chk("oe_start", of, st);
   endtask

   always @(negedge clk) begin
      if (!nReset || rst) begin
         trk = 1'b0;
         pb = busy;
      end else begin
         if (busy && !pb && !trk) begin
            trk = 1'b1; st = cyc;
            nr = 0; nw = 0; nd = 0; ndn = 0; noe = 0;
            sf = -1; sl = -1; dc = -1; dnc = -1; of = -1;
         end
         if (trk) begin
            if (DIOR || DIOW) begin
               if (sf < 0) sf = cyc;
               sl = cyc;
            end
            if (DIOR) nr++;
            if (DIOW) nw++;
            if (dstrb) begin nd++; dc = cyc; end
            if (done) begin ndn++; dnc = cyc; end
            if (oe) begin noe++; if (of < 0) of = cyc; end
            if (!busy) begin
               trk = 1'b0;
               fin();
               last_end = cyc;
            end
         end
         pb = busy;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(bit d, bit w, int L, bit q);
      exp_t e;
      e = mk(d, w, L, q);
      if (e.to) m_sticky = 1'b1;
      sb.push_back(e);
      lq.push_back(L);
      go = 1'b1; dev = d; we = w;
      step();
      go = 1'b0;
   endtask

   task automatic go_ign();
      go = 1'b1; dev = 1'($urandom); we = 1'($urandom);
      step();
      go = 1'b0;
   endtask

   task automatic load(bit d, int a, int b, int c, int e);
      logic [4*TW-1:0] v;
      v = {TW'(e), TW'(c), TW'(b), TW'(a)};
      if (d) begin T_d1 = v; ld_d1 = 1'b1; end
      else   begin T_d0 = v; ld_d0 = 1'b1; end
      step();
      ld_d0 = 1'b0; ld_d1 = 1'b0;
      m_t[d] = '{a, b, c, e};
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || busy || trk) && n < 3000) begin
         step();
         n++;
      end
      chk("drain_in_time", int'(n < 3000), 1);
      repeat (3) step();
      chk("idle_after_drain", busy, 0);
      chk("timeout_flag", timeout, m_sticky);
      if (m_sticky) begin
         clr_to = 1'b1; step(); clr_to = 1'b0;
         m_sticky = 1'b0;
         step();
         chk("timeout_cleared", timeout, 0);
      end
   endtask

   task automatic chk_quiet(string nm);
      chk(nm, {busy, oe, done, dstrb, DIOR, DIOW, timeout}, 0);
   endtask

   initial begin : main
      int n, tot, d, L;
      bit w, dv;
      exp_t e;
      nReset = 1'b0; rst = 1'b0; ld_d0 = 1'b0; ld_d1 = 1'b0;
      go = 1'b0; dev = 1'b0; we = 1'b0; IORDY = 1'b1; clr_to = 1'b0;
      T_d0 = '0; T_d1 = '0; IORDY_en = 2'b00; Tto = '0;
      model_reset();
      repeat (2) step();
      chk_quiet("reset_outputs");
      nReset = 1'b1;
      step();
      chk_quiet("post_reset_outputs");

      issue(0, 0, 0, 0);
      drain();

      load(1, 2, 3, 4, 1);
      issue(1, 1, 0, 0);
      drain();

      IORDY_en = 2'b01;
      issue(0, 0, 28 + 9, 0);
      drain();

      load(0, 0, 0, 0, 0);
      issue(0, 1, 0, 0);
      drain();
      issue(0, 0, 5, 0);
      drain();

      load(1, 1, 255, 1, 0);
      issue(1, 0, 0, 0);
      drain();

      issue(0, 0, 0, 0);
      step();
      issue(1, 1, 0, 1);
      go_ign();
      drain();

      load(0, 6, 28, 2, 23);
      IORDY_en = 2'b01;
      Tto = 5;
      issue(0, 0, 200, 0);
      drain();
      Tto = 0;
      issue(0, 0, 40, 0);
      drain();

      IORDY_en = 2'b00;
      issue(0, 0, 0, 0);
      repeat (8) step();
      issue(1, 1, 0, 1);
      n = 0;
      while (sb.size() != 1 && n < 500) begin step(); n++; end
      chk("queued_started", busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete(); lq.delete(); model_reset();
      chk_quiet("sync_reset_outputs");
      repeat (5) step();
      chk("queue_flushed", busy, 0);

      load(0, 3, 10, 2, 3);
      issue(0, 0, 0, 0);
      repeat (5) step();
      chk("dior_before_nreset", DIOR, 1);
      nReset = 1'b0;
      #1;
      chk_quiet("async_reset_outputs");
      step();
      nReset = 1'b1;
      sb.delete(); lq.delete(); model_reset();
      step();
      chk("idle_after_nreset", busy, 0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0)
            load(0, $urandom_range(0, 9), $urandom_range(0, 9),
                 $urandom_range(0, 9), $urandom_range(0, 9));
         if ($urandom_range(0, 2) == 0)
            load(1, $urandom_range(0, 9), $urandom_range(0, 9),
                 $urandom_range(0, 9), $urandom_range(0, 9));
         IORDY_en = 2'($urandom);
         Tto = TOW'($urandom_range(0, 6));
         dv = 1'($urandom); w = 1'($urandom);
         L = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 15);
         issue(dv, w, L, 0);
         if ($urandom_range(0, 1) == 1) begin
            e = sb[sb.size() - 1];
            tot = e.t1 + e.slen + e.hl;
            d = $urandom_range(0, tot - 2);
            repeat (d) step();
            dv = 1'($urandom); w = 1'($urandom);
            L = $urandom_range(0, 12);
            issue(dv, w, L, 1);
            if ($urandom_range(0, 1) == 1) go_ign();
         end
         drain();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
